// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_ctrl_pkg
//  Purpose  : Shared encodings for the RV32I control path. It holds the
//             opcode constants, the multi-cycle FSM state enum, the ALU
//             operation class, and the select encodings for alu_ctrl,
//             imm_src, result_src, alu_src_a and alu_src_b.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  // Opcodes decoded by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // alu_ctrl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  // imm_src encodings
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // result_src encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Multi-cycle FSM states (exactly 16, so 4 bits are fully used)
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL,
    S_JALR, S_JALR_WB, S_LUI, S_ILLEGAL
  } state_t;

  // What kind of ALU operation the current state wants
  typedef enum logic [1:0] {
    ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_R, ALU_CLS_I
  } alu_class_t;

endpackage : riscv_ctrl_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational ALU operation decoder. It is shared by the
//             single-cycle and the multi-cycle controllers.
//  Ports    : alu_class   in  - operation class requested by the controller
//             funct3      in  - instruction funct3
//             funct7      in  - instruction funct7
//             alu_ctrl    out - ALU operation
//             funct_undef out - funct encoding is not one we implement
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [2:0]  alu_ctrl,
  output logic        funct_undef
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_undef = 1'b0;
    case (alu_class)
      ALU_CLS_SUB: alu_ctrl = ALU_SUB;
      ALU_CLS_R: begin
        case ({funct7, funct3})
          10'd0:   alu_ctrl = ALU_ADD;
          10'd256: alu_ctrl = ALU_SUB;
          10'd7:   alu_ctrl = ALU_AND;
          10'd6:   alu_ctrl = ALU_OR;
          10'd2:   alu_ctrl = ALU_SLT;
          10'd4:   alu_ctrl = ALU_XOR;
          default: funct_undef = 1'b1;
        endcase
      end
      ALU_CLS_I: begin
        case (funct3)
          3'b000:  alu_ctrl = ALU_ADD;
          3'b110:  alu_ctrl = ALU_OR;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b111:  alu_ctrl = ALU_AND;
          default: funct_undef = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Control FSM for a shared-ALU, shared-memory multi-cycle RV32I
//             datapath. One instruction takes 3-5 cycles plus memory waits.
//  Config   : `define ILLEGAL_TRAP_EN makes ILLEGAL a sticky trap state and
//             sends undefined funct encodings there too. Without it, ILLEGAL
//             is a one-cycle no-op and illegal is tied to 0.
//  Params   : RESET_STATE_FETCH - 1: leave reset in FETCH, 0: in IDLE
//  Ports    : clk, rst_n (async, active low), start (leaves IDLE)
//             op/funct3/funct7 from IR, zero from ALU, mem_ready from memory
//             mem_req, mem_write, adr_src       - memory interface
//             ir_write, pc_write, reg_write     - register enables
//             alu_src_a, alu_src_b, alu_ctrl    - ALU controls
//             result_src, imm_src              - result / immediate selects
//             illegal                          - sticky illegal-opcode flag
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       illegal
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam state_t RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_IDLE;

  state_t     state;
  state_t     next_state;
  alu_class_t alu_class;
  logic [2:0] dec_alu_ctrl;
  logic       funct_undef;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= next_state;
  end

  // ALU class depends on state only; kept apart from the main decode so the
  // decoder output does not loop back into the block that drives its input.
  always_comb begin
    alu_class = ALU_CLS_ADD;
    case (state)
      S_EXEC_R: alu_class = ALU_CLS_R;
      S_EXEC_I: alu_class = ALU_CLS_I;
      S_BRANCH: alu_class = ALU_CLS_SUB;
      default:  alu_class = ALU_CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_ctrl    (dec_alu_ctrl),
    .funct_undef (funct_undef)
  );

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_ctrl   = dec_alu_ctrl;

    case (state)
      S_IDLE: begin
        if (start) next_state = S_FETCH;
      end
      S_FETCH: begin
        // PC+4 is written the same cycle the instruction word arrives
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while decoding
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = op[5] ? IMM_S : IMM_I;
        next_state = op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        next_state = (TRAP_EN && funct_undef) ? S_ILLEGAL : S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        next_state = (TRAP_EN && funct_undef) ? S_ILLEGAL : S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] inverts the sense: beq takes on zero, bne on not-zero
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        pc_write   = zero ^ funct3[0];
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        imm_src    = IMM_J;
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = S_JALR_WB;
      end
      S_JALR_WB: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_ILLEGAL: begin
        if (!TRAP_EN) next_state = S_FETCH;
      end
      default: next_state = RESET_STATE;
    endcase

    // The reset state is FETCH, which would otherwise request memory; hold
    // every output quiet while reset is asserted so an abandoned access
    // is dropped immediately.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      imm_src    = IMM_I;
      alu_ctrl   = ALU_ADD;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        illegal_q <= 1'b0;
    else if (next_state == S_ILLEGAL)  illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule : multicycle_controller
`default_nettype wire
